// File: rtl/flag_branch_ctrl.sv
// -----------------------------------------------------------------------------
// flag_branch_ctrl
//
// Owns the {Z,V,N} flag register written by the EX-stage ALU and resolves
// conditional branches sitting in ID against those registered flags. When the
// instruction in EX is about to rewrite flags, a branch in ID is held for one
// cycle (flag_stall) so that it resolves against the updated flags.
//
// Parameters
//   FLAG_RST      reset value of flags {Z,V,N}
//   CNT_W         width of the saturating flag-update counter
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   ex_valid      EX stage holds a real instruction
//   ex_alu_op     ALU opcode of the EX instruction
//   ex_result     ALU result of the EX instruction
//   ex_ovfl       ALU add/sub overflow of the EX instruction
//   stall_ex      EX held this cycle (instruction does not advance)
//   flush_ex      EX instruction squashed this cycle
//   id_is_branch  ID holds a conditional branch
//   id_cond       branch condition code
//   flags         registered flags {Z,V,N}
//   flag_stall    hold PC/IF/ID, bubble into EX
//   branch_taken  branch in ID resolves taken
//   upd_cnt       committed flag updates, saturating
// -----------------------------------------------------------------------------
module flag_branch_ctrl #(
  parameter logic [2:0] FLAG_RST = 3'b000,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_alu_op,
  input  logic [15:0]      ex_result,
  input  logic             ex_ovfl,
  input  logic             stall_ex,
  input  logic             flush_ex,
  input  logic             id_is_branch,
  input  logic [2:0]       id_cond,
  output logic [2:0]       flags,
  output logic             flag_stall,
  output logic             branch_taken,
  output logic [CNT_W-1:0] upd_cnt
);

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRA = 4'b0010;
  localparam logic [3:0] OP_ROR = 4'b0100;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic wr_full;   // writes Z, V and N
  logic wr_z;      // writes Z only
  logic writer;
  logic commit;
  logic flag_z, flag_v, flag_n;
  logic cond_met;

  assign wr_full = (ex_alu_op == OP_ADD) || (ex_alu_op == OP_SUB);
  assign wr_z    = (ex_alu_op == OP_XOR) || (ex_alu_op == OP_SLL) ||
                   (ex_alu_op == OP_SRA) || (ex_alu_op == OP_ROR);
  assign writer  = wr_full | wr_z;
  assign commit  = ex_valid & ~stall_ex & ~flush_ex;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags   <= FLAG_RST;
      upd_cnt <= '0;
    end else if (commit && writer) begin
      flags[2] <= (ex_result == 16'h0000);
      if (wr_full) begin
        flags[1] <= ex_ovfl;
        flags[0] <= ex_result[15];
      end
      if (upd_cnt != CNT_MAX) begin
        upd_cnt <= upd_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    cond_met = 1'b0;
    case (id_cond)
      3'b000:  cond_met = ~flag_z;                        // NE
      3'b001:  cond_met = flag_z;                         // EQ
      3'b010:  cond_met = ~flag_z & ~flag_n;              // GT
      3'b011:  cond_met = flag_n;                         // LT
      3'b100:  cond_met = flag_z | (~flag_z & ~flag_n);   // GE
      3'b101:  cond_met = flag_n | flag_z;                // LE
      3'b110:  cond_met = flag_v;                         // OV
      default: cond_met = 1'b1;                           // UN
    endcase
  end

  // The stall ignores id_cond on purpose: it only depends on whether the EX
  // instruction writes any flag, which keeps the hazard path shallow.
  // A bubble injected after a stall has ex_valid=0, so it cannot re-stall.
  assign flag_stall   = rst_n & id_is_branch & ex_valid & ~flush_ex & writer;
  assign branch_taken = rst_n & id_is_branch & ~flag_stall & cond_met;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
module tb_flag_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_alu_op = 4'h0;
  logic [15:0] ex_result = 16'h0;
  logic        ex_ovfl = 1'b0;
  logic        stall_ex = 1'b0;
  logic        flush_ex = 1'b0;
  logic        id_is_branch = 1'b0;
  logic [2:0]  id_cond = 3'b000;

  logic [2:0]  flags, flags2;
  logic        flag_stall, flag_stall2;
  logic        branch_taken, branch_taken2;
  logic [15:0] upd_cnt;
  logic [1:0]  upd_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flag_branch_ctrl #(.FLAG_RST(3'b000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .id_is_branch(id_is_branch), .id_cond(id_cond),
    .flags(flags), .flag_stall(flag_stall), .branch_taken(branch_taken),
    .upd_cnt(upd_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  flag_branch_ctrl #(.FLAG_RST(3'b000), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .id_is_branch(id_is_branch), .id_cond(id_cond),
    .flags(flags2), .flag_stall(flag_stall2), .branch_taken(branch_taken2),
    .upd_cnt(upd_cnt2)
  );

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ovf;
    logic        stl;
    logic        fl;
    logic        br;
    logic [2:0]  cc;
    logic [2:0]  e_flags;
    logic        e_stall;
    logic        e_taken;
    int          e_cnt;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ovf, input logic stl, input logic fl,
                       input logic br, input logic [2:0] cc);
    ex_valid = v; ex_alu_op = op; ex_result = res; ex_ovfl = ovf;
    stall_ex = stl; flush_ex = fl; id_is_branch = br; id_cond = cc;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [15:0] res,
                              input logic ovf, input logic stl, input logic fl,
                              input logic br, input logic [2:0] cc,
                              input logic [2:0] ef, input logic es, input logic et,
                              input int ec);
    vec_t r;
    r.v = v; r.op = op; r.res = res; r.ovf = ovf; r.stl = stl; r.fl = fl;
    r.br = br; r.cc = cc; r.e_flags = ef; r.e_stall = es; r.e_taken = et; r.e_cnt = ec;
    return r;
  endfunction

  // Reference model: which flags an opcode writes (2 = Z,V,N; 1 = Z; 0 = none).
  function automatic int mask_of(input logic [3:0] op);
    case (op)
      4'b1001, 4'b1010:                   return 2;
      4'b1011, 4'b0001, 4'b0010, 4'b0100: return 1;
      default:                            return 0;
    endcase
  endfunction

  function automatic logic cond_ok(input logic [2:0] cc, input logic z, input logic v,
                                   input logic n);
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int min3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  initial begin
    int sat_exp[5];
    logic mz, mv, mn;
    int   mcnt, mcnt2;
    logic e_stall, e_taken;

    sat_exp = '{1, 2, 3, 3, 3};

    tbl[0]  = mk(1, 4'b1001, 16'h0000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    tbl[1]  = mk(1, 4'b1011, 16'h8000, 0, 0, 0, 0, 3'b000, 3'b110, 0, 0, 1);
    tbl[2]  = mk(1, 4'b1000, 16'h1234, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 2);
    tbl[3]  = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 2);
    tbl[4]  = mk(1, 4'b1010, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b010, 1, 0, 2);
    tbl[5]  = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b100, 0, 1, 3);
    tbl[6]  = mk(1, 4'b1001, 16'h0001, 0, 0, 0, 0, 3'b000, 3'b100, 0, 0, 3);
    tbl[7]  = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b111, 3'b000, 0, 1, 4);
    tbl[8]  = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b000, 0, 1, 4);
    tbl[9]  = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b101, 3'b000, 0, 0, 4);
    tbl[10] = mk(1, 4'b1000, 16'h0000, 0, 0, 0, 1, 3'b110, 3'b000, 0, 0, 4);
    tbl[11] = mk(1, 4'b1010, 16'h8000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 4);
    tbl[12] = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b011, 3'b001, 0, 1, 5);
    tbl[13] = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b001, 0, 0, 5);
    tbl[14] = mk(1, 4'b1001, 16'h0000, 0, 0, 1, 1, 3'b011, 3'b001, 0, 1, 5);
    tbl[15] = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b001, 0, 0, 5);
    tbl[16] = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 0, 3'b111, 3'b001, 0, 0, 5);
    tbl[17] = mk(1, 4'b0001, 16'h0000, 0, 0, 0, 1, 3'b011, 3'b001, 1, 0, 5);
    tbl[18] = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b101, 0, 1, 6);
    tbl[19] = mk(1, 4'b1111, 16'h0000, 1, 0, 0, 1, 3'b110, 3'b101, 0, 0, 6);
    tbl[20] = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b101, 0, 0, 6);

    // Async reset mid-run with flags=111, count=5
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 4'b1001, 16'h0001, 0, 0, 0, 0, 3'b000);
    end
    @(negedge clk);
    drive(1, 4'b1001, 16'h8000, 1, 0, 0, 0, 3'b000);
    @(negedge clk);
    drive(1, 4'b1011, 16'h0000, 0, 0, 0, 0, 3'b000);
    @(negedge clk);
    drive(1, 4'b1001, 16'h0000, 0, 0, 0, 1, 3'b111);
    #1;
    check("pre_rst_flags", 32'(flags), 32'h7);
    check("pre_rst_cnt", 32'(upd_cnt), 32'd5);
    check("pre_rst_cnt2", 32'(upd_cnt2), 32'd3);
    check("pre_rst_stall", 32'(flag_stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_cnt", 32'(upd_cnt), 32'd0);
    check("rst_cnt2", 32'(upd_cnt2), 32'd0);
    check("rst_stall", 32'(flag_stall), 32'd0);
    check("rst_taken", 32'(branch_taken), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table (masks, hazard, conditions, flush)
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].op, tbl[i].res, tbl[i].ovf, tbl[i].stl, tbl[i].fl,
            tbl[i].br, tbl[i].cc);
      #1;
      check($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].e_flags));
      check($sformatf("tbl%0d_stall", i), 32'(flag_stall), 32'(tbl[i].e_stall));
      check($sformatf("tbl%0d_taken", i), 32'(branch_taken), 32'(tbl[i].e_taken));
      check($sformatf("tbl%0d_cnt", i), 32'(upd_cnt), 32'(tbl[i].e_cnt));
      check($sformatf("tbl%0d_cnt2", i), 32'(upd_cnt2), 32'(min3(tbl[i].e_cnt)));
    end

    // SUB held in EX by stall_ex for 3 cycles, then released
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 4'b1010, 16'h0000, 0, 1, 0, 1, 3'b001);
      #1;
      check($sformatf("hold%0d_stall", i), 32'(flag_stall), 32'd1);
      check($sformatf("hold%0d_taken", i), 32'(branch_taken), 32'd0);
      check($sformatf("hold%0d_cnt", i), 32'(upd_cnt), 32'd0);
    end
    @(negedge clk);
    drive(1, 4'b1010, 16'h0000, 0, 0, 0, 1, 3'b001);
    #1;
    check("release_stall", 32'(flag_stall), 32'd1);
    check("release_cnt", 32'(upd_cnt), 32'd0);
    @(negedge clk);
    drive(0, 4'b0000, 16'h0000, 0, 0, 0, 1, 3'b001);
    #1;
    check("after_stall", 32'(flag_stall), 32'd0);
    check("after_taken", 32'(branch_taken), 32'd1);
    check("after_flags", 32'(flags), 32'h4);
    check("after_cnt", 32'(upd_cnt), 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("after2_cnt", 32'(upd_cnt), 32'd1);

    // Saturation on the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 4'b1001, 16'h0001, 0, 0, 0, 0, 3'b000);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_cnt2", i), 32'(upd_cnt2), 32'(sat_exp[i]));
    end

    // Randomized run against the reference model
    do_reset();
    mz = 1'b0; mv = 1'b0; mn = 1'b0;
    mcnt = 0; mcnt2 = 0;
    for (int i = 0; i < 3000; i++) begin
      int m;
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)));
      #1;
      m = mask_of(ex_alu_op);
      e_stall = id_is_branch && ex_valid && !flush_ex && (m != 0);
      e_taken = id_is_branch && !e_stall && cond_ok(id_cond, mz, mv, mn);
      check("rnd_flags", 32'(flags), 32'({mz, mv, mn}));
      check("rnd_stall", 32'(flag_stall), 32'(e_stall));
      check("rnd_taken", 32'(branch_taken), 32'(e_taken));
      check("rnd_cnt", 32'(upd_cnt), 32'(mcnt));
      check("rnd_cnt2", 32'(upd_cnt2), 32'(mcnt2));
      if (ex_valid && !stall_ex && !flush_ex && m != 0) begin
        mz = (ex_result == 16'h0000);
        if (m == 2) begin
          mv = ex_ovfl;
          mn = ex_result[15];
        end
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
